// File: rtl/guess_sender.sv
// Stores up to MAXLEN button symbols, then replays them as one-cycle I1..I4 pulses
// separated by GAP idle cycles, finishing with an enter pulse and a done pulse.
module guess_sender #(
    parameter int unsigned MAXLEN = 7,
    parameter int unsigned GAP    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    input  logic [1:0] load_sym,
    output logic       load_ready,
    input  logic       start,
    input  logic       clr,
    output logic       I1,
    output logic       I2,
    output logic       I3,
    output logic       I4,
    output logic       enter,
    output logic       busy,
    output logic       done,
    output logic [2:0] count,
    output logic       drop_err
);

    localparam int unsigned DEPTH    = 8;
    localparam logic [2:0]  MAX3     = 3'(MAXLEN);
    localparam logic [2:0]  GAP_LAST = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRESS = 3'd1,
        GAPW  = 3'd2,
        ENTER = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic [2:0] index_q, index_d;
    logic [2:0] gap_q, gap_d;
    logic       drop_q, drop_d;
    logic [1:0] buf_q [DEPTH];
    logic [1:0] buf_d [DEPTH];

    logic [3:0] btn_q, btn_d;
    logic       enter_q, busy_q, done_q, ready_q;

    logic [2:0] nxt_idx;
    state_t     adv_state;
    logic [1:0] sym_sel;

    // Next-state, buffer and counter logic
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        index_d   = index_q;
        gap_d     = gap_q;
        drop_d    = drop_q;
        buf_d     = buf_q;
        nxt_idx   = 3'(index_q + 3'd1);
        adv_state = (nxt_idx < count_q) ? PRESS : ENTER;

        case (state_q)
            IDLE: begin
                // clr beats a simultaneous load; an accepted load is visible to start
                if (clr) begin
                    count_d = 3'd0;
                    drop_d  = 1'b0;
                end else if (load_valid) begin
                    if (count_q < MAX3) begin
                        buf_d[count_q] = load_sym;
                        count_d        = 3'(count_q + 3'd1);
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                if (start) begin
                    index_d = 3'd0;
                    state_d = (count_d != 3'd0) ? PRESS : ENTER;
                end
            end
            PRESS: begin
                gap_d = 3'd0;
                if (GAP == 0) begin
                    index_d = nxt_idx;
                    state_d = adv_state;
                end else begin
                    state_d = GAPW;
                end
            end
            GAPW: begin
                if (gap_q == GAP_LAST) begin
                    index_d = nxt_idx;
                    state_d = adv_state;
                end else begin
                    gap_d = 3'(gap_q + 3'd1);
                end
            end
            ENTER:   state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && load_valid) begin
            drop_d = 1'b1;
        end

        sym_sel = buf_d[index_d];
        btn_d   = (state_d == PRESS) ? 4'(4'b0001 << sym_sel) : 4'b0000;
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= 3'd0;
            index_q <= 3'd0;
            gap_q   <= 3'd0;
            drop_q  <= 1'b0;
            btn_q   <= 4'b0000;
            enter_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            gap_q   <= gap_d;
            drop_q  <= drop_d;
            btn_q   <= btn_d;
            enter_q <= (state_d == ENTER);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == FIN);
            ready_q <= (state_d == IDLE) && (count_d < MAX3);
        end
    end

    // Symbol storage needs no reset; count qualifies its contents
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign I1         = btn_q[0];
    assign I2         = btn_q[1];
    assign I3         = btn_q[2];
    assign I4         = btn_q[3];
    assign enter      = enter_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = ready_q;
    assign count      = count_q;
    assign drop_err   = drop_q;

endmodule

// File: tb/tb_guess_sender.sv
// Directed bench for guess_sender (MAXLEN=7, GAP=2); outputs sampled 1ns after each rising edge.
module tb_guess_sender;

    logic       clk = 1'b0;
    logic       reset, load_valid, start, clr;
    logic [1:0] load_sym;
    logic       load_ready, I1, I2, I3, I4, enter, busy, done, drop_err;
    logic [2:0] count;

    int ncmp  = 0;
    int nfail = 0;

    guess_sender #(.MAXLEN(7), .GAP(2)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_sym(load_sym),
        .load_ready(load_ready), .start(start), .clr(clr),
        .I1(I1), .I2(I2), .I3(I3), .I4(I4), .enter(enter),
        .busy(busy), .done(done), .count(count), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    // Packed view: {I1,I2,I3,I4,enter,done,busy,load_ready}
    function automatic logic [7:0] outs();
        return {I1, I2, I3, I4, enter, done, busy, load_ready};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then check one packed vector per following cycle.
    task automatic play(input string tag, input logic [7:0] exp [$], input bit inject);
        start = 1'b1;
        step();
        start      = 1'b0;
        load_valid = 1'b0;
        for (int i = 0; i < exp.size(); i++) begin
            chk($sformatf("%s_c%0d", tag, i + 1), outs(), exp[i]);
            if (inject && i == 1) begin
                start      = 1'b1;
                load_valid = 1'b1;
                load_sym   = 2'd1;
            end
            step();
            start      = 1'b0;
            load_valid = 1'b0;
        end
    endtask

    task automatic load(input logic [1:0] s);
        load_valid = 1'b1;
        load_sym   = s;
        step();
        load_valid = 1'b0;
    endtask

    logic [7:0] e40 [$];
    logic [7:0] e42 [$];
    logic [7:0] e45 [$];

    initial begin
        e40 = '{8'b1000_0010, 8'b0000_0010, 8'b0000_0010, 8'b0010_0010,
                8'b0000_0010, 8'b0000_0010, 8'b0001_0010, 8'b0000_0010,
                8'b0000_0010, 8'b0000_1010, 8'b0000_0110, 8'b0000_0001};
        e42 = '{8'b0000_1010, 8'b0000_0110, 8'b0000_0001};
        e45 = '{8'b0100_0010, 8'b0000_0010, 8'b0000_0010, 8'b0000_1010,
                8'b0000_0110, 8'b0000_0001};

        reset = 1'b1; load_valid = 1'b0; load_sym = 2'd0; start = 1'b0; clr = 1'b0;
        step();
        step();
        chk("reset_outs", outs(), 8'b0000_0001);
        chk("reset_cnt", 8'(count), 8'd0);
        chk("reset_drop", 8'(drop_err), 8'd0);
        reset = 1'b0;

        load(2'd0); load(2'd2); load(2'd3);
        chk("load3_cnt", 8'(count), 8'd3);
        chk("load3_drop", 8'(drop_err), 8'd0);

        play("play", e40, 1'b0);

        // start/load during playout: ignored, load dropped, same sequence
        play("inject", e40, 1'b1);
        chk("inject_drop", 8'(drop_err), 8'd1);
        chk("inject_cnt", 8'(count), 8'd3);

        play("replay", e40, 1'b0);

        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_cnt", 8'(count), 8'd0);
        chk("clr_drop", 8'(drop_err), 8'd0);

        play("empty", e42, 1'b0);

        load_valid = 1'b1; load_sym = 2'd1;
        play("ldstart", e45, 1'b0);
        chk("ldstart_cnt", 8'(count), 8'd1);

        // clr and load together: clr wins, no drop flag
        clr = 1'b1; load_valid = 1'b1; load_sym = 2'd2; step();
        clr = 1'b0; load_valid = 1'b0;
        chk("clrld_cnt", 8'(count), 8'd0);
        chk("clrld_drop", 8'(drop_err), 8'd0);

        for (int i = 0; i < 7; i++) load(2'(i));
        chk("full_cnt", 8'(count), 8'd7);
        chk("full_ready", 8'(load_ready), 8'd0);
        chk("full_drop0", 8'(drop_err), 8'd0);
        load(2'd3);
        chk("over_cnt", 8'(count), 8'd7);
        chk("over_drop", 8'(drop_err), 8'd1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr2_cnt", 8'(count), 8'd0);
        chk("clr2_drop", 8'(drop_err), 8'd0);
        chk("clr2_ready", 8'(load_ready), 8'd1);

        // reset sampled at edge 5 of a playout
        load(2'd0); load(2'd2); load(2'd3);
        start = 1'b1; step(); start = 1'b0;
        for (int c = 1; c < 5; c++) step();
        reset = 1'b1; step(); reset = 1'b0;
        for (int c = 6; c <= 12; c++) begin
            chk($sformatf("rstmid_c%0d", c), outs(), 8'b0000_0001);
            chk($sformatf("rstmid_cnt_c%0d", c), 8'(count), 8'd0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/guess_sender.md
GUESS_SENDER -- requirements
Module: guess_sender

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter MAXLEN, default 7, giving the maximum number of stored symbols (1..7).
REQ-002 The block SHALL have parameter GAP, default 2, giving the idle cycles after each button pulse (0..7).
Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port load_valid, input, 1, which offers load_sym for storage.
REQ-006 The block SHALL have port load_sym, input, 2, the symbol to store: 0=I1, 1=I2, 2=I3, 3=I4.
REQ-007 The block SHALL have port load_ready, output, 1, which is high when a load is accepted this cycle.
REQ-008 The block SHALL have port start, input, 1, which requests playout of the stored sequence.
REQ-009 The block SHALL have port clr, input, 1, which empties the buffer while idle.
REQ-010 The block SHALL have ports I1, I2, I3 and I4, outputs, 1 each, which carry one-cycle button pulses to the game.
REQ-011 The block SHALL have port enter, output, 1, a one-cycle enter pulse that terminates the sequence.
REQ-012 The block SHALL have port busy, output, 1, which is high while playout is in progress.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse marking playout completion.
REQ-014 The block SHALL have port count, output, 3, the number of stored symbols.
REQ-015 The block SHALL have port drop_err, output, 1, a sticky flag set when a load is refused.

Function
REQ-016 The FSM SHALL have states IDLE, PRESS, GAPW, ENTER and FIN; IDLE is the only state in which load, clr or start is honoured.
REQ-017 load_ready SHALL equal (state==IDLE && count<MAXLEN).
REQ-018 When load_valid and load_ready are both high, the block SHALL write load_sym at index count and increment count.
REQ-019 When load_valid is high and load_ready is low, the symbol SHALL be discarded and drop_err set.
REQ-020 drop_err SHALL clear only on reset or clr.
REQ-021 clr in IDLE SHALL set count to 0 and clear drop_err; clr outside IDLE SHALL be ignored.
REQ-022 If clr and load_valid occur in the same cycle, clr SHALL win and the load SHALL be dropped without setting drop_err.
REQ-023 If start and an accepted load occur in the same IDLE cycle, the load SHALL be stored first and playout SHALL include it.
REQ-024 start in IDLE with count>0 SHALL go to PRESS with index 0; with count==0 it SHALL go directly to ENTER.
REQ-025 start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-026 PRESS SHALL drive exactly one of I1..I4 high for one cycle, selected by the symbol at index, then go to GAPW (or to the next state directly if GAP==0).
REQ-027 GAPW SHALL hold all I1..I4 low for GAP cycles, then increment index and go to PRESS if index<count, otherwise to ENTER.
REQ-028 ENTER SHALL drive enter high for one cycle, then go to FIN.
REQ-029 FIN SHALL pulse done for one cycle, then return to IDLE.
REQ-030 busy SHALL be high in every state except IDLE.
REQ-031 Timing, with start sampled at edge t and N symbols: pulse k (0-based) SHALL be at cycle t+1+k*(GAP+1), enter at t+1+N*(GAP+1), and done one cycle after enter.
REQ-032 At most one of I1..I4 and enter SHALL ever be high in any cycle.
REQ-033 The buffer and count SHALL be retained after playout so that the same sequence can be replayed by another start.
REQ-034 The index counter SHALL be 3 bits and SHALL never wrap, since it is bounded by count<=MAXLEN<=7.

Reset
REQ-035 On reset high at a clock edge, the block SHALL enter IDLE.
REQ-036 On reset, count, index and drop_err SHALL be set to 0.
REQ-037 On reset, I1..I4, enter, busy and done SHALL be driven low.
REQ-038 On reset, load_ready SHALL be driven high from the next cycle.
REQ-039 Reset asserted mid-playout SHALL abort playout with no further pulses; buffer contents are don't-care.

Verification
REQ-040 With GAP=2, load symbols 0,2,3 then start at cycle 0 -> I1@1, I3@4, I4@7, enter@10, done@11, busy high cycles 1-11, load_ready high at cycle 12.
REQ-041 Load 8 symbols back-to-back with MAXLEN=7 -> count=7, load_ready low after the 7th load, 8th symbol dropped, drop_err=1; a subsequent clr sets count=0 and drop_err=0.
REQ-042 start with count=0 -> enter@1, done@2, with no I1..I4 pulses.
REQ-043 Pulse start and load_valid during playout -> no restart, load dropped, drop_err=1; after done, a new start replays the identical sequence.
REQ-044 Assert reset at cycle 5 of the REQ-040 playout -> no pulses from cycle 6 onward, busy=0, count=0.
REQ-045 load_valid(sym=1) and start in the same IDLE cycle with count=0 -> I2@1, enter@1+GAP+1.
